// File: rtl/prism_sp_cmd_wb_arbiter_if.sv
// Bundle of command-unit completion lines and the single writeback port
// shared between the arbiter (master) and the surrounding pipeline (slave).
interface prism_sp_cmd_wb_arbiter_if #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 3
);
  logic [NUM_UNITS-1:0]        unit_done;
  logic [NUM_UNITS*DATA_W-1:0] unit_rd;
  logic [NUM_UNITS*ID_W-1:0]   unit_id;
  logic [NUM_UNITS-1:0]        unit_ack;
  logic                        wb_done;
  logic [DATA_W-1:0]           wb_rd;
  logic [ID_W-1:0]             wb_id;
  logic                        wb_ack;
  logic [15:0]                 wb_count;

  modport master (
    input  unit_done, unit_rd, unit_id, wb_ack,
    output unit_ack, wb_done, wb_rd, wb_id, wb_count
  );

  modport slave (
    output unit_done, unit_rd, unit_id, wb_ack,
    input  unit_ack, wb_done, wb_rd, wb_id, wb_count
  );
endinterface

// File: rtl/prism_sp_cmd_wb_arbiter.sv
// Round-robin arbiter funnelling finished command-unit results into one
// single-entry writeback register, sustaining one result per cycle.
module prism_sp_cmd_wb_arbiter #(
  parameter int NUM_UNITS = 4,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 3
) (
  input logic clk,
  input logic rst,
  prism_sp_cmd_wb_arbiter_if.master bus
);
  localparam int PTR_W = $clog2(NUM_UNITS);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state, state_next;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0]  winner, idx;
  logic [PTR_W:0]    sum;
  logic              found, capture;
  logic [DATA_W-1:0] wb_rd_q;
  logic [ID_W-1:0]   wb_id_q;
  logic [15:0]       count_q;

  // First requesting unit at or above rr_ptr, wrapping modulo NUM_UNITS.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    sum    = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_UNITS)) sum = sum - (PTR_W+1)'(NUM_UNITS);
      idx = sum[PTR_W-1:0];
      if (!found && bus.unit_done[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_next   = state;
    rr_ptr_next  = rr_ptr;
    capture      = 1'b0;
    bus.unit_ack = '0;
    bus.wb_done  = (state == HOLD);
    // Acks are gated by rst so a held-high done cannot leak through reset.
    if (!rst && found && (state == IDLE || bus.wb_ack)) begin
      capture              = 1'b1;
      state_next           = HOLD;
      rr_ptr_next          = (winner == PTR_W'(NUM_UNITS-1)) ? '0 : winner + PTR_W'(1);
      bus.unit_ack[winner] = 1'b1;
    end else if (state == HOLD && bus.wb_ack) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_rd_q <= '0;
      wb_id_q <= '0;
      count_q <= '0;
    end else begin
      if (capture) begin
        wb_rd_q <= bus.unit_rd[int'(winner)*DATA_W +: DATA_W];
        wb_id_q <= bus.unit_id[int'(winner)*ID_W +: ID_W];
      end
      if (state == HOLD && bus.wb_ack) count_q <= count_q + 16'd1;
    end
  end

  assign bus.wb_rd    = wb_rd_q;
  assign bus.wb_id    = wb_id_q;
  assign bus.wb_count = count_q;
endmodule
